pcie_cq_bram_wr_bridge: RTL and testbench
=========================================

Name: pcie_cq_bram_wr_bridge

Overview:
- Sits directly downstream of pcie_cq_engine_64_dword and consumes its MEM_WR_* beat stream (data, address, keep, last, valid).
- Buffers beats in a small synchronous FIFO and drives the BAR-backed BRAM write port with byte enables.
- Generates the MEM_WR_BUSY backpressure that the CQ engine obeys.
- Waits for a BRAM grant from the shared-port arbiter, counts beats and packets, and flags protocol errors.

Parameters:
- DATA_W, 64 (`BRAM_DATA_WIDTH): beat and BRAM word width in bits.
- ADDR_W, 32 (`BRAM_ADDR_WIDTH): MEM_WR_ADDR width; a byte address.
- KEEP_W, 8 (`BRAM_KEEP_WIDTH): byte enables per beat, DATA_W/8.
- FIFO_DEPTH, 8: beat buffer depth; must be a power of 2 and at least 4.
- BRAM_AW, 10: BRAM word-address width.

Ports:
- CLK  in  1  system clock; all logic on rising edge.
- RST_N  in  1  synchronous active-low reset.
- MEM_WR_DATA  in  DATA_W  beat data from the CQ engine.
- MEM_WR_ADDR  in  ADDR_W  byte address of the beat; bits [2:0] must be 0.
- MEM_WR_KEEP  in  KEEP_W  byte valid; bit i covers DATA[8i+7:8i].
- MEM_WR_LAST  in  1  last beat of a TLP payload.
- MEM_WR_VALD  in  1  beat valid.
- MEM_WR_BUSY  out  1  registered backpressure to the CQ engine.
- BRAM_GNT  in  1  arbiter grants the BRAM write port this cycle.
- BRAM_REQ  out  1  write port requested (FIFO non-empty).
- BRAM_EN  out  1  BRAM enable.
- BRAM_WE  out  KEEP_W  per-byte write enable.
- BRAM_ADDR  out  BRAM_AW  word address, MEM_WR_ADDR[BRAM_AW+2:3].
- BRAM_DIN  out  DATA_W  write data.
- WR_PKT_CNT  out  16  count of completed packets (LAST beats retired); wraps.
- WR_ERR  out  2  sticky flags: [0] misaligned address, [1] FIFO overflow.

Behaviour:
- Reset, with RST_N sampled low at a clock edge: all outputs go to 0; FIFO pointers and count clear; FSM goes to IDLE. Reset mid-packet discards all buffered beats; nothing partial is written after reset.
- Accept rule: a beat is accepted when MEM_WR_VALD=1 and the registered MEM_WR_BUSY=0. It is also accepted in the cycle in which BUSY first rises, to absorb the in-flight beat.
- BUSY is registered: next BUSY = (count_next >= FIFO_DEPTH-2). Deassertion is likewise registered, one cycle after count drops.
- Overflow: VALD=1 while the FIFO is full and no pop occurs in that cycle. The beat is dropped and WR_ERR[1] is set.
- Misalignment: an accepted beat with ADDR[2:0]!=0 is still enqueued, but with keep forced to 0, and WR_ERR[0] is set. Its LAST is honoured.
- FIFO stores {LAST, KEEP, word addr, DATA}. Simultaneous push and pop leave the count unchanged. Pointers wrap modulo FIFO_DEPTH.
- BRAM_REQ = FIFO non-empty, registered from count_next.
- Drain FSM:
  - IDLE: when the FIFO is non-empty go to WAIT.
  - WAIT: when BRAM_GNT=1, pop the head and go to WRITE.
  - WRITE: output registers hold the popped beat for exactly one cycle: BRAM_EN=1, BRAM_WE=KEEP, ADDR, DIN.
    - If GNT=1 and the FIFO is still non-empty, pop the next beat and stay in WRITE (back-to-back, 1 beat/cycle).
    - Otherwise, if non-empty go to WAIT, else go to IDLE.
- A beat with KEEP=0 is popped and retired, but with BRAM_EN=0 and WE=0.
- Loss of GNT mid-packet only stalls; beat order is preserved.
- WR_PKT_CNT increments on the retire cycle of a beat with LAST=1 (including beats with keep forced to 0). It wraps 0xFFFF -> 0.
- Latency: a beat accepted at edge N, with the FIFO empty and GNT held high, gives BRAM_EN=1 during cycle N+2 (N+1 = WAIT pop, N+2 = WRITE).
- BRAM_EN and BRAM_WE are 0 in every non-WRITE cycle. BRAM_DIN and BRAM_ADDR hold their last values.
- WR_ERR clears only on reset.

Decomposition:
- Widths come from the shared bram_parameters.vh macros (`BRAM_DATA_WIDTH, `BRAM_ADDR_WIDTH, `BRAM_KEEP_WIDTH).
- FSM state encodings (IDLE=2'd0, WAIT=2'd1, WRITE=2'd2) are localparams in the module.
- The buffer is one sub-module, pcie_sync_fifo (parameterised width/depth, push/pop/full/empty/count). It is reusable by the CC path.

Test Plan:
- Single beat: addr 0x10, keep 0xFF, data 0x123, LAST=1, GNT tied 1 -> BRAM_EN=1, ADDR=2, WE=0xFF, DIN=0x123 two cycles after accept; WR_PKT_CNT=1.
- Two-beat packet 0x123 @0x8 (keep 0xFF), then 0x456 @0x10 (keep 0x0F, LAST) -> consecutive WRITE cycles at ADDR 1 and 2 with WE 0xFF then 0x0F; WR_PKT_CNT=1.
- Backpressure: GNT=0, VALD held for 8 beats -> BUSY rises after count reaches 6; exactly 7 beats accepted, no overflow; after GNT=1, 7 ordered writes follow and BUSY drops.
- Overflow: ignore BUSY and push a 9th beat into a full FIFO with GNT=0 -> beat dropped, WR_ERR=2'b10, the 8 buffered beats are written intact.
- Misaligned addr 0x0C with LAST -> no BRAM_EN pulse, WR_ERR[0]=1, WR_PKT_CNT increments.
- Reset asserted with 3 beats buffered -> next cycle all outputs 0, no BRAM writes after release; a subsequent single beat is written normally.

Source files
------------

// File: rtl/pcie_cq_bram_wr_bridge_pkg.sv
// rtl/pcie_cq_bram_wr_bridge_pkg.sv - shared constants and helpers for the CQ-to-BRAM write bridge
//
// Purpose: counter/flag widths, error-flag bit positions and the
// alignment helper used by pcie_cq_bram_wr_bridge.

package pcie_cq_bram_wr_bridge_pkg;

    localparam int unsigned PKT_CNT_W    = 16;
    localparam int unsigned ERR_W        = 2;
    localparam int unsigned ERR_MISALIGN = 0;
    localparam int unsigned ERR_OVERFLOW = 1;

    // BUSY asserts this many entries before full, leaving room for the
    // beat already in flight when the engine sees BUSY.
    localparam int unsigned BUSY_MARGIN  = 2;

    // Beats carry byte addresses of whole 64-bit words.
    function automatic logic addr_misaligned(input logic [2:0] addr_lo);
        return addr_lo != 3'd0;
    endfunction

endpackage

// File: rtl/pcie_sync_fifo.sv
// rtl/pcie_sync_fifo.sv - single-clock FIFO shared by the CQ and CC paths
//
// Purpose: DEPTH-entry synchronous FIFO with a combinational head
// (dout_o is the oldest entry whenever empty_o is low).
// Ports:
//   clk_i, rst_ni      clock, synchronous active-low reset
//   push_i, din_i      write one entry (ignored when full unless popping)
//   pop_i              retire the head entry (ignored when empty)
//   dout_o             head entry
//   full_o, empty_o    occupancy flags
//   count_o            current number of entries

module pcie_sync_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 8
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     push_i,
    input  logic [WIDTH-1:0]         din_i,
    input  logic                     pop_i,
    output logic [WIDTH-1:0]         dout_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [CW-1:0]    count_q;
    logic             do_push;
    logic             do_pop;

    assign full_o  = (count_q == CW'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign dout_o  = mem_q[rd_ptr_q];

    assign do_pop  = pop_i && !empty_o;
    // A pop in the same cycle frees the slot, so a full FIFO can still take a push.
    assign do_push = push_i && (!full_o || do_pop);

    always_ff @(posedge clk_i) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= din_i;
        end
    end

    // DEPTH is a power of two, so pointers wrap by natural overflow.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_q <= wr_ptr_q + AW'(1);
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            count_q <= count_q + CW'(do_push) - CW'(do_pop);
        end
    end

endmodule

// File: rtl/pcie_cq_bram_wr_bridge.sv
// rtl/pcie_cq_bram_wr_bridge.sv - buffers CQ engine write beats and drains them to the BAR BRAM port
//
// Purpose: accepts MEM_WR_* beats from pcie_cq_engine_64_dword, buffers
// them, raises MEM_WR_BUSY as backpressure, and writes them to the BRAM
// once the shared-port arbiter grants access.
// Ports:
//   CLK, RST_N                       clock, synchronous active-low reset
//   MEM_WR_DATA/ADDR/KEEP/LAST/VALD  beat stream from the CQ engine
//   MEM_WR_BUSY                      registered backpressure to the engine
//   BRAM_GNT, BRAM_REQ               arbiter handshake
//   BRAM_EN/WE/ADDR/DIN              BRAM write port
//   WR_PKT_CNT                       wrapping count of retired LAST beats
//   WR_ERR                           sticky {overflow, misaligned} flags

`ifndef BRAM_DATA_WIDTH
`define BRAM_DATA_WIDTH 64
`endif
`ifndef BRAM_ADDR_WIDTH
`define BRAM_ADDR_WIDTH 32
`endif
`ifndef BRAM_KEEP_WIDTH
`define BRAM_KEEP_WIDTH 8
`endif

module pcie_cq_bram_wr_bridge
    import pcie_cq_bram_wr_bridge_pkg::*;
#(
    parameter int unsigned DATA_W     = `BRAM_DATA_WIDTH,
    parameter int unsigned ADDR_W     = `BRAM_ADDR_WIDTH,
    parameter int unsigned KEEP_W     = `BRAM_KEEP_WIDTH,
    parameter int unsigned FIFO_DEPTH = 8,
    parameter int unsigned BRAM_AW    = 10
) (
    input  logic                 CLK,
    input  logic                 RST_N,
    input  logic [DATA_W-1:0]    MEM_WR_DATA,
    input  logic [ADDR_W-1:0]    MEM_WR_ADDR,
    input  logic [KEEP_W-1:0]    MEM_WR_KEEP,
    input  logic                 MEM_WR_LAST,
    input  logic                 MEM_WR_VALD,
    output logic                 MEM_WR_BUSY,
    input  logic                 BRAM_GNT,
    output logic                 BRAM_REQ,
    output logic                 BRAM_EN,
    output logic [KEEP_W-1:0]    BRAM_WE,
    output logic [BRAM_AW-1:0]   BRAM_ADDR,
    output logic [DATA_W-1:0]    BRAM_DIN,
    output logic [PKT_CNT_W-1:0] WR_PKT_CNT,
    output logic [ERR_W-1:0]     WR_ERR
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_WAIT  = 2'd1;
    localparam logic [1:0] ST_WRITE = 2'd2;

    typedef enum logic [1:0] {
        S_IDLE  = ST_IDLE,
        S_WAIT  = ST_WAIT,
        S_WRITE = ST_WRITE
    } state_e;

    localparam int unsigned CNT_W   = $clog2(FIFO_DEPTH) + 1;
    localparam int unsigned ENTRY_W = 1 + KEEP_W + BRAM_AW + DATA_W;

    state_e                 state_q;
    logic                   busy_q;
    logic                   req_q;
    logic                   en_q;
    logic [KEEP_W-1:0]      we_q;
    logic [BRAM_AW-1:0]     addr_q;
    logic [DATA_W-1:0]      din_q;
    logic [PKT_CNT_W-1:0]   pkt_cnt_q;
    logic [ERR_W-1:0]       err_q;

    logic                   fifo_full;
    logic                   fifo_empty;
    logic [CNT_W-1:0]       fifo_count;
    logic [CNT_W-1:0]       count_d;
    logic                   push;
    logic                   pop;
    logic                   misaligned;
    logic [KEEP_W-1:0]      push_keep;
    logic [ENTRY_W-1:0]     push_entry;
    logic [ENTRY_W-1:0]     head_entry;
    logic                   head_last;
    logic [KEEP_W-1:0]      head_keep;
    logic [BRAM_AW-1:0]     head_waddr;
    logic [DATA_W-1:0]      head_data;
    logic                   unused_addr_hi;

    // Upper byte-address bits lie outside the BRAM window.
    assign unused_addr_hi = ^MEM_WR_ADDR[ADDR_W-1:BRAM_AW+3];

    // BUSY is advisory to the engine: any beat that fits is taken, which
    // covers the in-flight beat of the cycle in which BUSY rises.
    assign push       = MEM_WR_VALD && (!fifo_full || pop);
    assign misaligned = addr_misaligned(MEM_WR_ADDR[2:0]);
    assign push_keep  = misaligned ? '0 : MEM_WR_KEEP;
    assign push_entry = {MEM_WR_LAST, push_keep, MEM_WR_ADDR[BRAM_AW+2:3], MEM_WR_DATA};

    assign {head_last, head_keep, head_waddr, head_data} = head_entry;

    assign pop     = !fifo_empty && BRAM_GNT && (state_q == S_WAIT || state_q == S_WRITE);
    assign count_d = fifo_count + CNT_W'(push) - CNT_W'(pop);

    pcie_sync_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_i   (CLK),
        .rst_ni  (RST_N),
        .push_i  (push),
        .din_i   (push_entry),
        .pop_i   (pop),
        .dout_o  (head_entry),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (fifo_count)
    );

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state_q   <= S_IDLE;
            busy_q    <= 1'b0;
            req_q     <= 1'b0;
            en_q      <= 1'b0;
            we_q      <= '0;
            addr_q    <= '0;
            din_q     <= '0;
            pkt_cnt_q <= '0;
            err_q     <= '0;
        end else begin
            busy_q <= (count_d >= CNT_W'(FIFO_DEPTH - BUSY_MARGIN));
            req_q  <= (count_d != '0);

            if (push && misaligned) begin
                err_q[ERR_MISALIGN] <= 1'b1;
            end
            if (MEM_WR_VALD && fifo_full && !pop) begin
                err_q[ERR_OVERFLOW] <= 1'b1;
            end

            // The popped beat is presented for exactly the following (WRITE) cycle.
            en_q <= 1'b0;
            we_q <= '0;
            if (pop) begin
                en_q   <= (head_keep != '0);
                we_q   <= head_keep;
                addr_q <= head_waddr;
                din_q  <= head_data;
                if (head_last) begin
                    pkt_cnt_q <= pkt_cnt_q + PKT_CNT_W'(1);
                end
            end

            // IDLE looks at count_d so a freshly pushed beat reaches WAIT next cycle.
            case (state_q)
                S_IDLE: begin
                    if (count_d != '0) begin
                        state_q <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (pop) begin
                        state_q <= S_WRITE;
                    end
                end
                S_WRITE: begin
                    if (!pop) begin
                        state_q <= (count_d != '0) ? S_WAIT : S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign MEM_WR_BUSY = busy_q;
    assign BRAM_REQ    = req_q;
    assign BRAM_EN     = en_q;
    assign BRAM_WE     = we_q;
    assign BRAM_ADDR   = addr_q;
    assign BRAM_DIN    = din_q;
    assign WR_PKT_CNT  = pkt_cnt_q;
    assign WR_ERR      = err_q;

endmodule

// File: tb/tb_pcie_cq_bram_wr_bridge.sv
// tb/tb_pcie_cq_bram_wr_bridge.sv - directed self-checking bench for pcie_cq_bram_wr_bridge

module tb_pcie_cq_bram_wr_bridge;

    logic        clk;
    logic        RST_N;
    logic [63:0] MEM_WR_DATA;
    logic [31:0] MEM_WR_ADDR;
    logic [7:0]  MEM_WR_KEEP;
    logic        MEM_WR_LAST;
    logic        MEM_WR_VALD;
    logic        MEM_WR_BUSY;
    logic        BRAM_GNT;
    logic        BRAM_REQ;
    logic        BRAM_EN;
    logic [7:0]  BRAM_WE;
    logic [9:0]  BRAM_ADDR;
    logic [63:0] BRAM_DIN;
    logic [15:0] WR_PKT_CNT;
    logic [1:0]  WR_ERR;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    logic [9:0]  log_addr[$];
    logic [7:0]  log_we[$];
    logic [63:0] log_din[$];
    int          log_cyc[$];

    pcie_cq_bram_wr_bridge dut (
        .CLK         (clk),
        .RST_N       (RST_N),
        .MEM_WR_DATA (MEM_WR_DATA),
        .MEM_WR_ADDR (MEM_WR_ADDR),
        .MEM_WR_KEEP (MEM_WR_KEEP),
        .MEM_WR_LAST (MEM_WR_LAST),
        .MEM_WR_VALD (MEM_WR_VALD),
        .MEM_WR_BUSY (MEM_WR_BUSY),
        .BRAM_GNT    (BRAM_GNT),
        .BRAM_REQ    (BRAM_REQ),
        .BRAM_EN     (BRAM_EN),
        .BRAM_WE     (BRAM_WE),
        .BRAM_ADDR   (BRAM_ADDR),
        .BRAM_DIN    (BRAM_DIN),
        .WR_PKT_CNT  (WR_PKT_CNT),
        .WR_ERR      (WR_ERR)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (RST_N && BRAM_EN) begin
            log_addr.push_back(BRAM_ADDR);
            log_we.push_back(BRAM_WE);
            log_din.push_back(BRAM_DIN);
            log_cyc.push_back(cyc);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_beat(input logic [63:0] d, input logic [31:0] a, input logic [7:0] k, input logic l);
        MEM_WR_DATA = d;
        MEM_WR_ADDR = a;
        MEM_WR_KEEP = k;
        MEM_WR_LAST = l;
        MEM_WR_VALD = 1'b1;
    endtask

    task automatic idle_in();
        MEM_WR_VALD = 1'b0;
        MEM_WR_LAST = 1'b0;
    endtask

    task automatic clear_log();
        log_addr.delete();
        log_we.delete();
        log_din.delete();
        log_cyc.delete();
    endtask

    task automatic do_reset();
        RST_N    = 1'b0;
        BRAM_GNT = 1'b0;
        idle_in();
        tick();
        tick();
        RST_N = 1'b1;
        clear_log();
    endtask

    task automatic test_reset();
        RST_N = 1'b0;
        idle_in();
        BRAM_GNT = 1'b0;
        tick();
        tick();
        checks++; if (MEM_WR_BUSY !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", MEM_WR_BUSY); end
        checks++; if (BRAM_REQ !== 1'b0) begin errors++; $display("FAIL reset_req: got %b expected 0", BRAM_REQ); end
        checks++; if (BRAM_EN !== 1'b0 || BRAM_WE !== 8'h00) begin errors++; $display("FAIL reset_en_we: got en=%b we=%h expected 0/00", BRAM_EN, BRAM_WE); end
        checks++; if (BRAM_ADDR !== 10'h0 || BRAM_DIN !== 64'h0) begin errors++; $display("FAIL reset_addr_din: got %h/%h expected 0/0", BRAM_ADDR, BRAM_DIN); end
        checks++; if (WR_PKT_CNT !== 16'h0 || WR_ERR !== 2'b00) begin errors++; $display("FAIL reset_cnt_err: got %h/%b expected 0/00", WR_PKT_CNT, WR_ERR); end
        RST_N = 1'b1;
    endtask

    task automatic test_single_beat();
        do_reset();
        BRAM_GNT = 1'b1;
        set_beat(64'h123, 32'h10, 8'hFF, 1'b1);
        tick();
        idle_in();
        checks++; if (BRAM_EN !== 1'b0 || BRAM_REQ !== 1'b1) begin errors++; $display("FAIL single_wait: got en=%b req=%b expected 0/1", BRAM_EN, BRAM_REQ); end
        tick();
        checks++; if (BRAM_EN !== 1'b1 || BRAM_WE !== 8'hFF) begin errors++; $display("FAIL single_en_we: got en=%b we=%h expected 1/ff", BRAM_EN, BRAM_WE); end
        checks++; if (BRAM_ADDR !== 10'd2 || BRAM_DIN !== 64'h123) begin errors++; $display("FAIL single_addr_din: got %h/%h expected 002/123", BRAM_ADDR, BRAM_DIN); end
        tick();
        checks++; if (BRAM_EN !== 1'b0 || BRAM_WE !== 8'h00 || BRAM_DIN !== 64'h123) begin errors++; $display("FAIL single_after: got en=%b we=%h din=%h expected 0/00/123", BRAM_EN, BRAM_WE, BRAM_DIN); end
        checks++; if (WR_PKT_CNT !== 16'd1 || BRAM_REQ !== 1'b0) begin errors++; $display("FAIL single_cnt: got cnt=%0d req=%b expected 1/0", WR_PKT_CNT, BRAM_REQ); end
    endtask

    task automatic test_two_beat();
        do_reset();
        BRAM_GNT = 1'b1;
        set_beat(64'h123, 32'h8, 8'hFF, 1'b0);
        tick();
        set_beat(64'h456, 32'h10, 8'h0F, 1'b1);
        tick();
        idle_in();
        repeat (5) tick();
        checks++;
        if (log_addr.size() != 2) begin
            errors++; $display("FAIL two_beat_count: got %0d writes expected 2", log_addr.size());
        end else begin
            if (log_addr[0] !== 10'd1 || log_we[0] !== 8'hFF || log_din[0] !== 64'h123) begin errors++; $display("FAIL two_beat_w0: got %h/%h/%h expected 001/ff/123", log_addr[0], log_we[0], log_din[0]); end
            checks++;
            if (log_addr[1] !== 10'd2 || log_we[1] !== 8'h0F || log_din[1] !== 64'h456) begin errors++; $display("FAIL two_beat_w1: got %h/%h/%h expected 002/0f/456", log_addr[1], log_we[1], log_din[1]); end
            checks++;
            if (log_cyc[1] - log_cyc[0] != 1) begin errors++; $display("FAIL two_beat_b2b: got gap %0d expected 1", log_cyc[1] - log_cyc[0]); end
        end
        checks++; if (WR_PKT_CNT !== 16'd1) begin errors++; $display("FAIL two_beat_cnt: got %0d expected 1", WR_PKT_CNT); end
    endtask

    task automatic test_backpressure();
        int   sent;
        int   rise_at;
        logic prev_busy;
        do_reset();
        sent      = 0;
        rise_at   = -1;
        prev_busy = 1'b0;
        // Engine model: sends while BUSY is low, plus one in-flight beat on the rise.
        for (int c = 0; c < 12; c++) begin
            if (MEM_WR_BUSY && !prev_busy && rise_at < 0) rise_at = sent;
            if (sent < 8 && (!MEM_WR_BUSY || !prev_busy)) begin
                set_beat(64'hA000 + 64'(sent), 32'h100 + 32'(8 * sent), 8'hFF, (sent == 3 || sent == 6));
                sent++;
            end else begin
                idle_in();
            end
            prev_busy = MEM_WR_BUSY;
            tick();
        end
        idle_in();
        checks++; if (rise_at != 6) begin errors++; $display("FAIL bp_rise: got busy after %0d beats expected 6", rise_at); end
        checks++; if (sent != 7 || MEM_WR_BUSY !== 1'b1) begin errors++; $display("FAIL bp_stall: got sent=%0d busy=%b expected 7/1", sent, MEM_WR_BUSY); end
        checks++; if (log_addr.size() != 0 || WR_ERR !== 2'b00) begin errors++; $display("FAIL bp_nowrite: got writes=%0d err=%b expected 0/00", log_addr.size(), WR_ERR); end
        BRAM_GNT = 1'b1;
        repeat (12) tick();
        checks++;
        if (log_addr.size() != 7) begin
            errors++; $display("FAIL bp_drain_count: got %0d writes expected 7", log_addr.size());
        end else begin
            for (int i = 0; i < 7; i++) begin
                checks++;
                if (log_addr[i] !== 10'h20 + 10'(i) || log_din[i] !== 64'hA000 + 64'(i)) begin
                    errors++; $display("FAIL bp_order[%0d]: got %h/%h expected %h/%h", i, log_addr[i], log_din[i], 10'h20 + 10'(i), 64'hA000 + 64'(i));
                end
            end
        end
        checks++; if (MEM_WR_BUSY !== 1'b0 || BRAM_REQ !== 1'b0 || WR_PKT_CNT !== 16'd2) begin errors++; $display("FAIL bp_end: got busy=%b req=%b cnt=%0d expected 0/0/2", MEM_WR_BUSY, BRAM_REQ, WR_PKT_CNT); end
    endtask

    task automatic test_overflow();
        do_reset();
        for (int i = 0; i < 9; i++) begin
            set_beat(64'hB000 + 64'(i), 32'h200 + 32'(8 * i), 8'hFF, (i >= 7));
            tick();
        end
        idle_in();
        checks++; if (WR_ERR !== 2'b10) begin errors++; $display("FAIL ovf_err: got %b expected 10", WR_ERR); end
        checks++; if (log_addr.size() != 0 || MEM_WR_BUSY !== 1'b1) begin errors++; $display("FAIL ovf_hold: got writes=%0d busy=%b expected 0/1", log_addr.size(), MEM_WR_BUSY); end
        BRAM_GNT = 1'b1;
        repeat (14) tick();
        checks++;
        if (log_addr.size() != 8) begin
            errors++; $display("FAIL ovf_drain_count: got %0d writes expected 8", log_addr.size());
        end else begin
            for (int i = 0; i < 8; i++) begin
                checks++;
                if (log_addr[i] !== 10'h40 + 10'(i) || log_din[i] !== 64'hB000 + 64'(i)) begin
                    errors++; $display("FAIL ovf_data[%0d]: got %h/%h expected %h/%h", i, log_addr[i], log_din[i], 10'h40 + 10'(i), 64'hB000 + 64'(i));
                end
            end
        end
        checks++; if (WR_PKT_CNT !== 16'd1 || WR_ERR !== 2'b10) begin errors++; $display("FAIL ovf_end: got cnt=%0d err=%b expected 1/10", WR_PKT_CNT, WR_ERR); end
    endtask

    task automatic test_misaligned();
        do_reset();
        BRAM_GNT = 1'b1;
        set_beat(64'hDEAD, 32'h0C, 8'hFF, 1'b1);
        tick();
        idle_in();
        repeat (5) tick();
        checks++; if (log_addr.size() != 0) begin errors++; $display("FAIL mis_nowrite: got %0d writes expected 0", log_addr.size()); end
        checks++; if (WR_ERR !== 2'b01) begin errors++; $display("FAIL mis_err: got %b expected 01", WR_ERR); end
        checks++; if (WR_PKT_CNT !== 16'd1) begin errors++; $display("FAIL mis_cnt: got %0d expected 1", WR_PKT_CNT); end
    endtask

    task automatic test_reset_mid();
        do_reset();
        BRAM_GNT = 1'b1;
        set_beat(64'h77, 32'h30, 8'hFF, 1'b1);
        tick();
        idle_in();
        repeat (4) tick();
        BRAM_GNT = 1'b0;
        for (int i = 0; i < 3; i++) begin
            set_beat(64'hC100 + 64'(i), 32'h80 + 32'(8 * i), 8'hFF, (i == 2));
            tick();
        end
        idle_in();
        checks++; if (BRAM_REQ !== 1'b1 || BRAM_DIN !== 64'h77) begin errors++; $display("FAIL rmid_pre: got req=%b din=%h expected 1/77", BRAM_REQ, BRAM_DIN); end
        clear_log();
        RST_N = 1'b0;
        tick();
        checks++; if (BRAM_REQ !== 1'b0 || MEM_WR_BUSY !== 1'b0 || BRAM_EN !== 1'b0) begin errors++; $display("FAIL rmid_ctl: got req=%b busy=%b en=%b expected 0/0/0", BRAM_REQ, MEM_WR_BUSY, BRAM_EN); end
        checks++; if (BRAM_DIN !== 64'h0 || BRAM_ADDR !== 10'h0 || WR_PKT_CNT !== 16'h0) begin errors++; $display("FAIL rmid_data: got din=%h addr=%h cnt=%0d expected 0/0/0", BRAM_DIN, BRAM_ADDR, WR_PKT_CNT); end
        BRAM_GNT = 1'b1;
        RST_N    = 1'b1;
        repeat (6) tick();
        checks++; if (log_addr.size() != 0 || BRAM_REQ !== 1'b0) begin errors++; $display("FAIL rmid_flush: got writes=%0d req=%b expected 0/0", log_addr.size(), BRAM_REQ); end
        set_beat(64'h55, 32'h20, 8'h3C, 1'b1);
        tick();
        idle_in();
        repeat (4) tick();
        checks++;
        if (log_addr.size() != 1) begin
            errors++; $display("FAIL rmid_after_count: got %0d writes expected 1", log_addr.size());
        end else if (log_addr[0] !== 10'd4 || log_we[0] !== 8'h3C || log_din[0] !== 64'h55) begin
            errors++; $display("FAIL rmid_after_data: got %h/%h/%h expected 004/3c/55", log_addr[0], log_we[0], log_din[0]);
        end
        checks++; if (WR_PKT_CNT !== 16'd1) begin errors++; $display("FAIL rmid_cnt: got %0d expected 1", WR_PKT_CNT); end
    endtask

    initial begin
        RST_N       = 1'b0;
        BRAM_GNT    = 1'b0;
        MEM_WR_DATA = '0;
        MEM_WR_ADDR = '0;
        MEM_WR_KEEP = '0;
        MEM_WR_LAST = 1'b0;
        MEM_WR_VALD = 1'b0;
        test_reset();
        test_single_beat();
        test_two_beat();
        test_backpressure();
        test_overflow();
        test_misaligned();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
